// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main-control FSM and the MIPS datapath/memory.
// master = controller (drives strobes and selects), slave = datapath side (drives opcode, mem_ready).
// Purely combinational wiring; the mem_ready handshake stalls the controller in memory states.
interface multicycle_control_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            mem_ready;
  logic            pc_write;
  logic            pc_write_cond;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_source;
  logic            instr_done;
  logic            illegal;
  logic [3:0]      state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main-control FSM: Moore strobes/selects registered from the next state.
// Latency: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles; +1 per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
// Backpressure: mem_ready=0 holds FETCH/MEMRD/MEMWR with requests and iord stable.
// MC_CTRL_ILLEGAL_TRAP_EN: illegal opcode traps into HALT (held until reset) instead of acting as a NOP.
module multicycle_control #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(0),
  parameter logic [OP_W-1:0] OP_LW    = OP_W'(35),
  parameter logic [OP_W-1:0] OP_SW    = OP_W'(43),
  parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(4),
  parameter logic [OP_W-1:0] OP_ADDI  = OP_W'(8),
  parameter logic [OP_W-1:0] OP_J     = OP_W'(2)
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // Per-state control word; fetch/done_rdy mark outputs that also need mem_ready.
  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
    logic       done_rdy;
  } ctl_t;

  state_t state_q, state_d, state_nx;
  ctl_t   ctl_q, ctl_d;
  logic   is_sw_q, is_sw_d;
  logic   op_legal;

  // Opcode classification for the illegal pulse in DECODE
  always_comb begin
    op_legal = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) || (bus.opcode == OP_SW) ||
               (bus.opcode == OP_BEQ) || (bus.opcode == OP_ADDI) || (bus.opcode == OP_J);
  end

  // Next-state logic; reset overrides to FETCH so the registered outputs follow
  always_comb begin
    state_nx = state_q;
    is_sw_d  = is_sw_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        is_sw_d = (bus.opcode == OP_SW);
        if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) state_nx = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                    state_nx = S_EXEC;
        else if (bus.opcode == OP_BEQ)                      state_nx = S_BRANCH;
        else if (bus.opcode == OP_ADDI)                     state_nx = S_ADDIEX;
        else if (bus.opcode == OP_J)                        state_nx = S_JUMP;
        else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_nx = S_HALT;
`else
          state_nx = S_FETCH;
`endif
        end
      end
      S_MEMADR: state_nx = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_nx = S_MEMWB;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_nx = S_FETCH;
      S_EXEC:   state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_ADDIWB: state_nx = S_FETCH;
      S_JUMP:   state_nx = S_FETCH;
      S_HALT: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        state_nx = S_HALT;
`else
        state_nx = S_FETCH;
`endif
      end
      default:  state_nx = S_FETCH;
    endcase
    state_d = rst_n ? state_nx : S_FETCH;
  end

  // Control word of the state being entered, so outputs come straight from flops
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH:  begin ctl_d.fetch = 1'b1; ctl_d.mem_read = 1'b1; ctl_d.alu_src_b = 2'b01; end
      S_DECODE: ctl_d.alu_src_b = 2'b11;
      S_MEMADR: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10; end
      S_MEMRD:  begin ctl_d.mem_read = 1'b1; ctl_d.iord = 1'b1; end
      S_MEMWB:  begin ctl_d.reg_write = 1'b1; ctl_d.mem_to_reg = 1'b1; ctl_d.done = 1'b1; end
      S_MEMWR:  begin ctl_d.mem_write = 1'b1; ctl_d.iord = 1'b1; ctl_d.done_rdy = 1'b1; end
      S_EXEC:   begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_op = 2'b10; end
      S_ALUWB:  begin ctl_d.reg_dst = 1'b1; ctl_d.reg_write = 1'b1; ctl_d.done = 1'b1; end
      S_BRANCH: begin
        ctl_d.alu_src_a     = 1'b1;
        ctl_d.alu_op        = 2'b01;
        ctl_d.pc_write_cond = 1'b1;
        ctl_d.pc_source     = 2'b01;
        ctl_d.done          = 1'b1;
      end
      S_ADDIEX: begin ctl_d.alu_src_a = 1'b1; ctl_d.alu_src_b = 2'b10; end
      S_ADDIWB: begin ctl_d.reg_write = 1'b1; ctl_d.done = 1'b1; end
      S_JUMP:   begin ctl_d.pc_write = 1'b1; ctl_d.pc_source = 2'b10; ctl_d.done = 1'b1; end
      default:  ctl_d = '0;
    endcase
  end

  // State, store/load flag and control-word registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
    ctl_q <= ctl_d;
  end

  // Strobes are forced low while rst_n=0; selects fall back to FETCH values
  assign bus.pc_write      = rst_n & (ctl_q.pc_write | (ctl_q.fetch & bus.mem_ready));
  assign bus.ir_write      = rst_n & ctl_q.fetch & bus.mem_ready;
  assign bus.pc_write_cond = rst_n & ctl_q.pc_write_cond;
  assign bus.mem_read      = rst_n & ctl_q.mem_read;
  assign bus.mem_write     = rst_n & ctl_q.mem_write;
  assign bus.reg_write     = rst_n & ctl_q.reg_write;
  assign bus.iord          = rst_n & ctl_q.iord;
  assign bus.mem_to_reg    = rst_n & ctl_q.mem_to_reg;
  assign bus.reg_dst       = rst_n & ctl_q.reg_dst;
  assign bus.alu_src_a     = rst_n & ctl_q.alu_src_a;
  assign bus.alu_src_b     = rst_n ? ctl_q.alu_src_b : 2'b01;
  assign bus.alu_op        = rst_n ? ctl_q.alu_op    : 2'b00;
  assign bus.pc_source     = rst_n ? ctl_q.pc_source : 2'b00;
  assign bus.instr_done    = rst_n & (ctl_q.done | (ctl_q.done_rdy & bus.mem_ready));
  assign bus.illegal       = rst_n & (state_q == S_DECODE) & ~op_legal;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: path-per-opcode model plus per-cycle compare and literal checks.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Honors MC_CTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] op;

  always #5 clk = ~clk;

  multicycle_control_if #(.OP_W(6)) bus ();
  assign bus.opcode    = op;
  assign bus.mem_ready = mem_ready;

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  int    vec = 0;
  int    miss = 0;
  bit    chk_en = 1'b0;
  int    m_path [5] = '{0, 1, 0, 0, 0};
  int    m_len = 2;
  int    m_idx = 0;
  outs_t out_log [$];
  int    st_log  [$];

  function automatic bit legal(input logic [5:0] o);
    return (o == 6'd0) || (o == 6'd35) || (o == 6'd43) || (o == 6'd4) || (o == 6'd8) || (o == 6'd2);
  endfunction

  // Required outputs of a state, straight from the state table of the control description
  function automatic outs_t expect_out(input int st, input logic rdy, input logic rn, input logic [5:0] o);
    outs_t e;
    e = '0;
    e.state = 4'(st);
    if (!rn) begin
      e.alu_src_b = 2'b01;
      return e;
    end
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      1:  begin e.alu_src_b = 2'b11; e.illegal = !legal(o); end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = rdy; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; e.instr_done = 1; end
      9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      10: begin e.reg_write = 1; e.instr_done = 1; end
      11: begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Whole state sequence an instruction walks through (without stalls)
  task automatic load_path(input logic [5:0] o);
    m_path[0] = 0;
    m_path[1] = 1;
    case (o)
      6'd35:   begin m_path[2] = 2; m_path[3] = 3; m_path[4] = 4; m_len = 5; end
      6'd43:   begin m_path[2] = 2; m_path[3] = 5; m_len = 4; end
      6'd0:    begin m_path[2] = 6; m_path[3] = 7; m_len = 4; end
      6'd8:    begin m_path[2] = 9; m_path[3] = 10; m_len = 4; end
      6'd4:    begin m_path[2] = 8; m_len = 3; end
      6'd2:    begin m_path[2] = 11; m_len = 3; end
      default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        m_path[2] = 12;
        m_len = 3;
`else
        m_len = 2;
`endif
      end
    endcase
  endtask

  // Model: advance along the path, stalling in memory-waiting states, halting in 12
  initial forever begin
    int cur;
    @(posedge clk);
    cur = m_path[m_idx];
    if (!rst_n) begin
      m_path[0] = 0;
      m_path[1] = 1;
      m_len = 2;
      m_idx = 0;
    end else if (cur == 12) begin
      m_idx = m_idx;
    end else if (((cur == 0) || (cur == 3) || (cur == 5)) && !mem_ready) begin
      m_idx = m_idx;
    end else begin
      if (cur == 1) load_path(op);
      m_idx = m_idx + 1;
      if (m_idx >= m_len) m_idx = 0;
    end
  end

  // Per-cycle compare of every output against the model
  initial forever begin
    outs_t got, e;
    @(negedge clk);
    if (chk_en) begin
      got.pc_write      = bus.pc_write;
      got.pc_write_cond = bus.pc_write_cond;
      got.iord          = bus.iord;
      got.mem_read      = bus.mem_read;
      got.mem_write     = bus.mem_write;
      got.ir_write      = bus.ir_write;
      got.mem_to_reg    = bus.mem_to_reg;
      got.reg_dst       = bus.reg_dst;
      got.reg_write     = bus.reg_write;
      got.alu_src_a     = bus.alu_src_a;
      got.alu_src_b     = bus.alu_src_b;
      got.alu_op        = bus.alu_op;
      got.pc_source     = bus.pc_source;
      got.instr_done    = bus.instr_done;
      got.illegal       = bus.illegal;
      got.state         = bus.state;
      e = expect_out(m_path[m_idx], mem_ready, rst_n, op);
      vec++;
      if (got !== e) begin
        miss++;
        $display("FAIL cycle_compare t=%0t model_state=%0d got=%h exp=%h", $time, m_path[m_idx], got, e);
      end
      st_log.push_back(int'(bus.state));
      out_log.push_back(got);
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    vec++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Expected states packed one per nibble, cycle 0 in the lowest nibble
  task automatic check_states(input string nm, input int n, input logic [63:0] seq);
    check({nm, "_cycles"}, st_log.size(), n);
    for (int i = 0; i < n && i < st_log.size(); i++)
      check({nm, "_state"}, st_log[i], int'(seq[4*i +: 4]));
  endtask

  function automatic int n_done();
    int c = 0;
    foreach (out_log[i]) c += int'(out_log[i].instr_done);
    return c;
  endfunction

  function automatic int n_illegal();
    int c = 0;
    foreach (out_log[i]) c += int'(out_log[i].illegal);
    return c;
  endfunction

  task automatic clr();
    out_log.delete();
    st_log.delete();
  endtask

  task automatic run(input logic [5:0] o, input int n, input logic [31:0] rdy);
    op = o;
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy[i];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    op = 6'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Reset held two edges
    check("rst_state", int'(bus.state), 0);
    check("rst_strobes", int'({bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write,
                               bus.ir_write, bus.reg_write}), 0);
    check("rst_alu_src_b", int'(bus.alu_src_b), 1);
    rst_n = 1'b1;

    // LW, no stalls; first cycle is also the first fetch after reset
    clr();
    run(6'd35, 5, 32'hFFFF_FFFF);
    check("first_mem_read", int'(out_log[0].mem_read), 1);
    check("first_ir_write", int'(out_log[0].ir_write), 1);
    check("first_pc_write", int'(out_log[0].pc_write), 1);
    check_states("lw", 5, 64'h43210);
    check("lw_reg_write", int'(out_log[4].reg_write), 1);
    check("lw_mem_to_reg", int'(out_log[4].mem_to_reg), 1);
    check("lw_done_cnt", n_done(), 1);
    check("lw_done_last", int'(out_log[4].instr_done), 1);

    // LW with two FETCH stall cycles and one MEMRD stall cycle
    clr();
    run(6'd35, 8, 32'hFFFF_FFDC);
    check_states("lw_stall", 8, 64'h43321000);
    check("lw_stall_fetch_rd", int'(out_log[1].mem_read), 1);
    check("lw_stall_fetch_ir", int'(out_log[1].ir_write), 0);
    check("lw_stall_fetch_pc", int'(out_log[1].pc_write), 0);
    check("lw_stall_iord", int'(out_log[5].iord & out_log[6].iord), 1);
    check("lw_stall_memrd", int'(out_log[5].mem_read & out_log[6].mem_read), 1);
    check("lw_stall_done_cnt", n_done(), 1);

    // SW with three MEMWR stall cycles
    clr();
    run(6'd43, 7, 32'hFFFF_FFC7);
    check_states("sw", 7, 64'h5555210);
    for (int i = 3; i < 6; i++) begin
      check("sw_stall_write", int'(out_log[i].mem_write & out_log[i].iord), 1);
      check("sw_stall_done", int'(out_log[i].instr_done), 0);
    end
    check("sw_done_last", int'(out_log[6].instr_done), 1);
    check("sw_done_cnt", n_done(), 1);

    // R-type, BEQ, J back to back
    clr();
    run(6'd0, 4, 32'hFFFF_FFFF);
    check_states("rtype", 4, 64'h7610);
    check("rtype_reg_dst", int'(out_log[3].reg_dst), 1);
    check("rtype_alu_op", int'(out_log[2].alu_op), 2);
    clr();
    run(6'd4, 3, 32'hFFFF_FFFF);
    check_states("beq", 3, 64'h810);
    check("beq_pc_write_cond", int'(out_log[2].pc_write_cond), 1);
    check("beq_pc_source", int'(out_log[2].pc_source), 1);
    clr();
    run(6'd2, 3, 32'hFFFF_FFFF);
    check_states("j", 3, 64'hB10);
    check("j_pc_source", int'(out_log[2].pc_source), 2);
    check("j_pc_write", int'(out_log[2].pc_write), 1);

    // ADDI
    clr();
    run(6'd8, 4, 32'hFFFF_FFFF);
    check_states("addi", 4, 64'hA910);
    check("addi_reg_write", int'(out_log[3].reg_write), 1);
    check("addi_reg_dst", int'(out_log[3].reg_dst), 0);

    // Illegal opcode
    clr();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    run(6'd63, 12, 32'hFFFF_FFFF);
    check_states("halt", 12, 64'hCCCC_CCCC_CC10);
    check("illegal_pulse", int'(out_log[1].illegal), 1);
    check("illegal_cnt", n_illegal(), 1);
    for (int i = 2; i < 12; i++)
      check("halt_strobes", int'({out_log[i].pc_write, out_log[i].pc_write_cond, out_log[i].mem_read,
                                  out_log[i].mem_write, out_log[i].ir_write, out_log[i].reg_write}), 0);
`else
    run(6'd63, 2, 32'hFFFF_FFFF);
    check_states("illegal_nop", 2, 64'h10);
    check("illegal_pulse", int'(out_log[1].illegal), 1);
    check("illegal_cnt", n_illegal(), 1);
    clr();
    run(6'd2, 3, 32'hFFFF_FFFF);
    check_states("after_illegal_j", 3, 64'hB10);
`endif

    // Reset asserted while in MEMRD abandons the load
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(6'd35, 3, 32'hFFFF_FFFF);
    clr();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(6'd35, 2, 32'hFFFF_FFFF);
    check_states("mid_reset", 3, 64'h103);
    check("mid_reset_mem_read", int'(out_log[0].mem_read), 0);
    check("mid_reset_reg_write", int'(out_log[0].reg_write | out_log[1].reg_write | out_log[2].reg_write), 0);
    check("mid_reset_done", n_done(), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
